// File: rtl/alligator_stream.sv
// alligator_stream
//
// Streaming Williams-Alligator trend detector. Each accepted price sample goes
// into a BLUE_LEN-deep circular history; three window sums (blue/red/green) are
// updated incrementally. Once the history is full, every new sample triggers a
// serial restoring division of each sum by its window length (blue, red, green
// in turn, one quotient bit per cycle) followed by a buy/sell/hold decision.
//
// Ports
//   Clk            rising-edge clock
//   Rst            synchronous active-high reset
//   in_valid       sample present
//   in_ready       block can accept a sample (IDLE only)
//   in_price       unsigned price sample
//   out_valid      one-cycle pulse: new result on recommendation / *_avg
//   recommendation 0 = buy, 1 = sell, 2 = hold
//   blue_avg, red_avg, green_avg  latest window averages (truncated)
//
// Build option
//   ALLIGATOR_CONFIRM_EN  when defined, a changed raw decision must be seen on
//                         two consecutive evaluations before recommendation
//                         follows it.
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a sample, in_ready = 1
// UPDATE | update window sums, write history, advance pointer/count
// DIV    | serial division of blue, red, green sums
// CMP    | result presented, out_valid = 1

module alligator_stream #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BLUE_LEN  = 13,
    parameter int unsigned RED_LEN   = 8,
    parameter int unsigned GREEN_LEN = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_price,
    output logic              out_valid,
    output logic [1:0]        recommendation,
    output logic [DATA_W-1:0] blue_avg,
    output logic [DATA_W-1:0] red_avg,
    output logic [DATA_W-1:0] green_avg
);

    localparam int unsigned SUM_W  = DATA_W + $clog2(BLUE_LEN + 1);
    localparam int unsigned PTR_W  = $clog2(BLUE_LEN);
    localparam int unsigned PTRX_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(BLUE_LEN + 1);
    // partial remainder is < 2*L before the trial subtract
    localparam int unsigned REM_W  = $clog2(BLUE_LEN + 1) + 1;
    localparam int unsigned BIT_W  = $clog2(SUM_W);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DIV, S_CMP} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  buf_q [BLUE_LEN];
    logic [DATA_W-1:0]  buf_d [BLUE_LEN];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  price_q, price_d;
    logic [SUM_W-1:0]   sum_blue_q, sum_blue_d;
    logic [SUM_W-1:0]   sum_red_q, sum_red_d;
    logic [SUM_W-1:0]   sum_green_q, sum_green_d;
    logic [SUM_W-1:0]   quo_q, quo_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [1:0]         line_q, line_d;
    logic [DATA_W-1:0]  blue_avg_q, blue_avg_d;
    logic [DATA_W-1:0]  red_avg_q, red_avg_d;
    logic [DATA_W-1:0]  green_avg_q, green_avg_d;
    logic [1:0]         rec_q, rec_d;
`ifdef ALLIGATOR_CONFIRM_EN
    logic [1:0]         last_raw_q, last_raw_d;
    logic               pending_q, pending_d;
`endif

    // Index of the sample leaving a window of length len: (ptr - len) mod BLUE_LEN.
    function automatic logic [PTR_W-1:0] old_idx(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned len);
        logic [PTRX_W-1:0] t;
        t = {1'b0, ptr} + PTRX_W'(BLUE_LEN - len);
        if (t >= PTRX_W'(BLUE_LEN)) begin
            t = t - PTRX_W'(BLUE_LEN);
        end
        return t[PTR_W-1:0];
    endfunction

    function automatic logic [1:0] decide(input logic [DATA_W-1:0] b,
                                          input logic [DATA_W-1:0] r,
                                          input logic [DATA_W-1:0] g);
        if (b > r && r > g) begin
            return 2'd1;
        end else if (b < r && r < g) begin
            return 2'd0;
        end
        return 2'd2;
    endfunction

    // Incremental window sums; unfilled history slots are zero, so warm-up
    // falls out naturally.
    logic [SUM_W-1:0] sum_blue_nx, sum_red_nx, sum_green_nx;
    assign sum_blue_nx  = sum_blue_q  + SUM_W'(price_q) - SUM_W'(buf_q[old_idx(wr_ptr_q, BLUE_LEN)]);
    assign sum_red_nx   = sum_red_q   + SUM_W'(price_q) - SUM_W'(buf_q[old_idx(wr_ptr_q, RED_LEN)]);
    assign sum_green_nx = sum_green_q + SUM_W'(price_q) - SUM_W'(buf_q[old_idx(wr_ptr_q, GREEN_LEN)]);

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = (cnt_q == CNT_W'(BLUE_LEN)) ? cnt_q : cnt_q + CNT_W'(1);

    // Restoring divider step: the dividend shifts out of quo_q MSB-first while
    // quotient bits shift in at the LSB.
    logic [REM_W-1:0] div_len, rem_sh, rem_nx;
    logic [SUM_W-1:0] quo_nx;
    logic             ge;
    logic [1:0]       raw_dec;

    assign div_len = (line_q == 2'd0) ? REM_W'(BLUE_LEN) :
                     (line_q == 2'd1) ? REM_W'(RED_LEN)  : REM_W'(GREEN_LEN);
    assign rem_sh  = {rem_q[REM_W-2:0], quo_q[SUM_W-1]};
    assign ge      = (rem_sh >= div_len);
    assign rem_nx  = ge ? (rem_sh - div_len) : rem_sh;
    assign quo_nx  = {quo_q[SUM_W-2:0], ge};
    // On the final green step quo_nx already holds the green quotient.
    assign raw_dec = decide(blue_avg_q, red_avg_q, quo_nx[DATA_W-1:0]);

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        price_d     = price_q;
        sum_blue_d  = sum_blue_q;
        sum_red_d   = sum_red_q;
        sum_green_d = sum_green_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        bit_d       = bit_q;
        line_d      = line_q;
        blue_avg_d  = blue_avg_q;
        red_avg_d   = red_avg_q;
        green_avg_d = green_avg_q;
        rec_d       = rec_q;
`ifdef ALLIGATOR_CONFIRM_EN
        last_raw_d  = last_raw_q;
        pending_d   = pending_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    price_d = in_price;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                sum_blue_d       = sum_blue_nx;
                sum_red_d        = sum_red_nx;
                sum_green_d      = sum_green_nx;
                buf_d[wr_ptr_q]  = price_q;
                wr_ptr_d         = (wr_ptr_q == PTR_W'(BLUE_LEN - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                cnt_d            = cnt_inc;
                if (cnt_inc == CNT_W'(BLUE_LEN)) begin
                    state_d = S_DIV;
                    quo_d   = sum_blue_nx;
                    rem_d   = '0;
                    bit_d   = '0;
                    line_d  = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                quo_d = quo_nx;
                rem_d = rem_nx;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(SUM_W - 1)) begin
                    bit_d = '0;
                    rem_d = '0;
                    case (line_q)
                        2'd0: begin
                            blue_avg_d = quo_nx[DATA_W-1:0];
                            quo_d      = sum_red_q;
                            line_d     = 2'd1;
                        end
                        2'd1: begin
                            red_avg_d = quo_nx[DATA_W-1:0];
                            quo_d     = sum_green_q;
                            line_d    = 2'd2;
                        end
                        default: begin
                            green_avg_d = quo_nx[DATA_W-1:0];
                            state_d     = S_CMP;
`ifdef ALLIGATOR_CONFIRM_EN
                            if (raw_dec != last_raw_q) begin
                                last_raw_d = raw_dec;
                                pending_d  = 1'b1;
                            end else if (pending_q) begin
                                rec_d     = raw_dec;
                                pending_d = 1'b0;
                            end
`else
                            rec_d = raw_dec;
`endif
                        end
                    endcase
                end
            end
            S_CMP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < int'(BLUE_LEN); i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            price_q     <= '0;
            sum_blue_q  <= '0;
            sum_red_q   <= '0;
            sum_green_q <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            bit_q       <= '0;
            line_q      <= '0;
            blue_avg_q  <= '0;
            red_avg_q   <= '0;
            green_avg_q <= '0;
            rec_q       <= 2'd2;
`ifdef ALLIGATOR_CONFIRM_EN
            last_raw_q  <= 2'd2;
            pending_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            price_q     <= price_d;
            sum_blue_q  <= sum_blue_d;
            sum_red_q   <= sum_red_d;
            sum_green_q <= sum_green_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            bit_q       <= bit_d;
            line_q      <= line_d;
            blue_avg_q  <= blue_avg_d;
            red_avg_q   <= red_avg_d;
            green_avg_q <= green_avg_d;
            rec_q       <= rec_d;
`ifdef ALLIGATOR_CONFIRM_EN
            last_raw_q  <= last_raw_d;
            pending_q   <= pending_d;
`endif
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign out_valid      = (state_q == S_CMP);
    assign recommendation = rec_q;
    assign blue_avg       = blue_avg_q;
    assign red_avg        = red_avg_q;
    assign green_avg      = green_avg_q;

endmodule

// File: tb/tb_alligator_stream.sv
// Testbench for alligator_stream (default parameters 32/13/8/5).
// Stimulus pushes hand-computed expected results into a scoreboard queue; a
// forked monitor pops and compares whenever out_valid is seen.
module tb_alligator_stream;

    localparam int LAT = 110;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_price;
    logic        out_valid;
    logic [1:0]  recommendation;
    logic [31:0] blue_avg, red_avg, green_avg;

    alligator_stream dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_price(in_price), .out_valid(out_valid), .recommendation(recommendation),
        .blue_avg(blue_avg), .red_avg(red_avg), .green_avg(green_avg)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  rec;
        logic [31:0] b, r, g;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    int last_out_cyc = 0;

    // recommendation filter model
    logic [1:0] cf_last = 2'd2;
    logic       cf_pend = 1'b0;
    logic [1:0] cf_rec  = 2'd2;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        cf_last = 2'd2;
        cf_pend = 1'b0;
        cf_rec  = 2'd2;
    endtask

    task automatic model_eval(input logic [1:0] raw, output logic [1:0] rec);
`ifdef ALLIGATOR_CONFIRM_EN
        if (raw != cf_last) begin
            cf_last = raw;
            cf_pend = 1'b1;
        end else if (cf_pend) begin
            cf_rec  = raw;
            cf_pend = 1'b0;
        end
`else
        cf_rec = raw;
`endif
        rec = cf_rec;
    endtask

    task automatic mon_out();
        exp_t e;
        forever begin
            @(negedge Clk);
            if (out_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("recommendation", recommendation, e.rec);
                    check("blue_avg", blue_avg, e.b);
                    check("red_avg", red_avg, e.r);
                    check("green_avg", green_avg, e.g);
                    check("latency", cyc - e.acc, LAT);
                    last_out_cyc = cyc;
                end
            end
        end
    endtask

    task automatic mon_hs();
        forever begin
            @(posedge Clk);
            if (Rst === 1'b0 && in_valid === 1'b1 && in_ready === 1'b1) hs_cnt++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send(input logic [31:0] p, input bit has_exp, input logic [1:0] raw,
                        input logic [31:0] b, input logic [31:0] r, input logic [31:0] g,
                        output int acc);
        int   n;
        exp_t e;
        logic [1:0] rec;
        in_valid = 1'b1;
        in_price = p;
        n = 0;
        while (in_ready !== 1'b1 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
        end
        acc = cyc;
        if (has_exp) begin
            model_eval(raw, rec);
            e.rec = rec; e.b = b; e.r = r; e.g = g; e.acc = acc;
            sbq.push_back(e);
        end
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_recommendation"}, recommendation, 2);
        check({tag, "_blue_avg"}, blue_avg, 0);
        check({tag, "_red_avg"}, red_avg, 0);
        check({tag, "_green_avg"}, green_avg, 0);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        in_valid = 1'b1;
        in_price = 32'd999;
        @(negedge Clk);
        @(negedge Clk);
        check_reset_state("reset");
        Rst = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        model_reset();
        @(negedge Clk);
    endtask

    initial begin
        int acc, prev, t0, hs_base, n;
        logic [31:0] p;
        Rst = 1'b1;
        in_valid = 1'b0;
        in_price = '0;
        fork
            mon_out();
            mon_hs();
        join_none
        @(negedge Clk);

        // reset with in_valid held high
        do_reset();

        // warm-up: 12 x 500 silent, 13th yields 500/500/500 hold
        hs_base = hs_cnt;
        prev = 0;
        for (int i = 0; i < 13; i++) begin
            send(32'd500, (i == 12), 2'd2, 32'd500, 32'd500, 32'd500, acc);
            if (i > 0) check("warmup_accept_gap", acc - prev, 2);
            prev = acc;
        end
        check("warmup_handshakes", hs_cnt - hs_base, 13);

        // rising ramp 100..119, then one very low sample
        do_reset();
        for (int i = 0; i < 20; i++) begin
            p = 32'(100 + i);
            send(p, (i >= 12), 2'd0, p - 32'd6, p - 32'd4, p - 32'd2, acc);
        end
        send(32'd0, 1'b1, 2'd1, 32'd104, 32'd101, 32'd94, acc);

        // falling ramp 112..100, then a stalled sample during the division
        do_reset();
        hs_base = hs_cnt;
        for (int i = 0; i < 13; i++) begin
            p = 32'(112 - i);
            send(p, (i == 12), 2'd1, 32'd106, 32'd103, 32'd102, acc);
        end
        t0 = acc;
        send(32'd200, 1'b1, 2'd0, 32'd112, 32'd115, 32'd121, acc);
        check("stall_accept_cycle", acc - t0, LAT + 1);
        check("accept_after_pulse", acc, last_out_cyc + 1);
        check("stall_handshakes", hs_cnt - hs_base, 14);

        // abort during the division
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        send(32'd300, 1'b0, 2'd2, 32'd0, 32'd0, 32'd0, acc);
        repeat (20) @(negedge Clk);
        check("abort_busy_in_ready", in_ready, 0);
        Rst = 1'b1;
        @(negedge Clk);
        check_reset_state("abort");
        Rst = 1'b0;
        sbq.delete();
        model_reset();
        repeat (150) @(negedge Clk);
        hs_base = hs_cnt;
        for (int i = 0; i < 13; i++) begin
            send(32'd40, (i == 12), 2'd2, 32'd40, 32'd40, 32'd40, acc);
        end
        check("post_abort_handshakes", hs_cnt - hs_base, 13);

        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        check("scoreboard_drained", sbq.size(), 0);
        repeat (5) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alligator_stream.md
# alligator_stream

Streaming, parametrised Williams-Alligator trend detector. It accepts one price sample per handshake into a circular history buffer and maintains three running window sums (blue/red/green) incrementally. When a sample arrives, it divides each sum by its window length on a shared serial divider and emits a buy/sell/hold recommendation. It sits between the price-feed source and the strategy/decision logic, replacing the fixed 13/8/5 batch evaluator that read a hard-coded table once.

## Interface
- DATA_W, 32, price sample width (unsigned)
- BLUE_LEN, 13, slow window length; history depth equals BLUE_LEN; legal range 3..16
- RED_LEN, 8, medium window length; GREEN_LEN < RED_LEN < BLUE_LEN
- GREEN_LEN, 5, fast window length; ≥1
- Clk  input  1  clock; all logic on rising edge
- Rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample present
- in_ready  output  1  block can accept a sample
- in_price  input  DATA_W  sample value
- out_valid  output  1  one-cycle pulse: new result
- recommendation  output  2  0 = buy, 1 = sell, 2 = hold
- blue_avg, red_avg, green_avg  output  DATA_W each  latest averages, truncated toward zero

## Operation
- SUM_W = DATA_W + $clog2(BLUE_LEN + 1); sums are unsigned, cannot overflow.
- Buffer: BLUE_LEN registers, cleared on reset; write pointer wraps BLUE_LEN-1 → 0.
- sample_cnt saturates at BLUE_LEN.
- FSM states:
  - IDLE: in_ready = 1. Accept on in_valid & in_ready; go to UPDATE.
  - UPDATE (1 cycle): each sum += new − buffer[wr_ptr − L mod BLUE_LEN]. Unfilled entries are 0, so warm-up needs no special case. Write the sample, advance the pointer, increment the count. If sample_cnt (post-increment) < BLUE_LEN, go to IDLE and emit no result; otherwise go to DIV.
  - DIV: restoring divider, one quotient bit per cycle, SUM_W cycles per line. Order is blue, red, green. Each quotient is loaded into its *_avg register on completion. Then go to CMP.
  - CMP (1 cycle): apply the rule below, pulse out_valid, go to IDLE.
- Recommendation rule: blue > red > green → 1 (sell); blue < red < green → 0 (buy); anything else, including any equality → 2 (hold).
- in_ready = 0 in UPDATE, DIV and CMP. A held in_valid stalls; samples are never dropped or duplicated.
- There is no output backpressure; out_valid is informational.

## Timing
- Reset values: in_ready = 1, out_valid = 0, recommendation = 2, all averages = 0, sums = 0, sample_cnt = 0, wr_ptr = 0, FSM in IDLE, buffer = 0.
- Rst mid-operation (any state) aborts the computation; the next cycle matches the reset state. No out_valid is produced for the aborted sample.
- Accept at cycle T. Sums are valid at T+1. out_valid and the new recommendation/averages appear at cycle T + 2 + 3·SUM_W (110 at defaults).
- The next sample can be accepted in the cycle after the out_valid pulse (CMP → IDLE), or at T+2 during warm-up.
- recommendation and *_avg hold their values between pulses.

## Configuration
- ALLIGATOR_CONFIRM_EN defined:
  - The raw decision must match on two consecutive evaluations before recommendation changes.
  - A one-bit "pending" register plus the last raw decision are kept; both are cleared on reset, and the last raw decision resets to hold.
  - out_valid still pulses on every evaluation.
- ALLIGATOR_CONFIRM_EN undefined: recommendation takes the raw decision immediately in CMP.

## Test plan
- Reset check: assert Rst with in_valid = 1 → in_ready = 1, out_valid = 0, recommendation = 2, averages = 0, no sample accepted.
- Warm-up: feed 12 samples of 500 → no out_valid. The 13th sample → out_valid exactly 110 cycles after acceptance, all averages = 500, recommendation = 2.
- Rising ramp 100..119, 20 samples, with buffer wrap → final result green = 117, red = 115, blue = 113, recommendation = 0.
- Falling ramp 112 down to 100, 13 samples → green = 102, red = 103, blue = 106, recommendation = 1.
- Backpressure and abort:
  - Hold in_valid high with a new price during DIV → in_ready = 0 and no accept until after out_valid; the sample count equals the number of handshakes.
  - Assert Rst during DIV → reset state next cycle, and no out_valid for that sample.
- ALLIGATOR_CONFIRM_EN build:
  - After a rising ramp gives two buy evaluations, the first evaluation keeps 2 and the second gives 0.
  - A single sell evaluation after that leaves 0.
